bus_cycle_sequencer: RTL and testbench

// Master timing generator for the 64 MHz system clock. Divides each 1 us CPU cycle into 64 ticks.

---
 rtl/bus_cycle_sequencer.sv | 68 ++++++
 tb/tb_bus_cycle_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// Splits each 1 us CPU cycle into 64 system-clock ticks and decodes the bus, PHI2, pixel,
// shift-load and Wishbone grant timing from that tick count. Latency 0: outputs register the decode of the new count.
module bus_cycle_sequencer #(
  parameter int GUARD_TICKS = 2
) (
  input  logic sys_clock_i,
  input  logic reset_ni,
  input  logic cpu_hold_i,
  output logic cpu_be_o,
  output logic cpu_clock_o,
  output logic cpu_wr_strobe_o,
  output logic clk8_en_o,
  output logic clk16_en_o,
  output logic load_sr1_o,
  output logic load_sr2_o,
  output logic grant_o,
  output logic grant_valid_o
);

  localparam logic [2:0] LP_VALID_END = 3'(8 - GUARD_TICKS);

  logic [5:0] r_cnt;
  logic       r_hold;

  logic [5:0] w_cnt_nxt;
  logic       w_hold_nxt;
  logic [2:0] w_slot;
  logic       w_fpga_owned;

  // Outputs decode the count being loaded on this edge, so they line up with r_cnt.
  always_comb begin
    w_cnt_nxt    = r_cnt + 6'd1;
    w_hold_nxt   = (r_cnt == 6'd63) ? cpu_hold_i : r_hold;
    w_slot       = w_cnt_nxt[5:3];
    w_fpga_owned = (w_slot <= 3'd2) || w_hold_nxt;
  end

  always_ff @(posedge sys_clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt           <= 6'd63;
      r_hold          <= 1'b0;
      cpu_be_o        <= 1'b0;
      cpu_clock_o     <= 1'b0;
      cpu_wr_strobe_o <= 1'b0;
      clk8_en_o       <= 1'b0;
      clk16_en_o      <= 1'b0;
      load_sr1_o      <= 1'b0;
      load_sr2_o      <= 1'b0;
      grant_o         <= 1'b0;
      grant_valid_o   <= 1'b0;
    end else begin
      r_cnt           <= w_cnt_nxt;
      r_hold          <= w_hold_nxt;
      // A held cycle keeps PHI2 stretched low; the 65C02 is static so this is safe.
      cpu_be_o        <= !w_hold_nxt && (w_cnt_nxt >= 6'd24);
      cpu_clock_o     <= !w_hold_nxt && w_cnt_nxt[5];
      cpu_wr_strobe_o <= !w_hold_nxt && (w_cnt_nxt == 6'd62);
      clk8_en_o       <= (w_cnt_nxt[2:0] == 3'd7);
      clk16_en_o      <= (w_cnt_nxt[1:0] == 2'd3);
      load_sr1_o      <= (w_cnt_nxt == 6'd63);
      load_sr2_o      <= (w_cnt_nxt == 6'd31);
      grant_o         <= (w_slot == 3'd2) || ((w_slot >= 3'd3) && w_hold_nxt);
      // Last GUARD_TICKS of every slot are withheld so the granted controller can drain.
      grant_valid_o   <= w_fpga_owned && (w_cnt_nxt[2:0] < LP_VALID_END);
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer with a tick-level reference model and per-cycle totals.
module tb_bus_cycle_sequencer;

  localparam int G = 2;

  logic clk, rst_n, hold;
  logic be, phi2, wr, c8, c16, sr1, sr2, gnt, gv;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt  = 63;
  int m_hold = 0;
  bit m_live = 0;

  bus_cycle_sequencer #(.GUARD_TICKS(G)) dut (
    .sys_clock_i(clk), .reset_ni(rst_n), .cpu_hold_i(hold),
    .cpu_be_o(be), .cpu_clock_o(phi2), .cpu_wr_strobe_o(wr),
    .clk8_en_o(c8), .clk16_en_o(c16), .load_sr1_o(sr1), .load_sr2_o(sr2),
    .grant_o(gnt), .grant_valid_o(gv)
  );

  initial begin
    clk = 0;
    forever #8 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t tick=%0d)", name, act, exp, $time, m_cnt);
    end
  endtask

  // Reference: position within the microsecond cycle and whether the cycle was donated to SPI.
  function automatic logic [8:0] model(input int t, input int h);
    int slot;
    bit be_e, ph_e, wr_e, c8_e, c16_e, s1_e, s2_e, g_e, gv_e, fpga;
    slot  = t / 8;
    be_e  = (h == 0) && (t >= 24);
    ph_e  = (h == 0) && (t / 32 == 1);
    wr_e  = (h == 0) && (t == 62);
    c8_e  = (t % 8) == 7;
    c16_e = (t % 4) == 3;
    s1_e  = t == 63;
    s2_e  = t == 31;
    fpga  = (slot <= 2) || (h != 0);
    g_e   = (slot == 2) || ((slot >= 3) && (h != 0));
    gv_e  = fpga && ((t % 8) < 8 - G);
    return {be_e, ph_e, wr_e, c8_e, c16_e, s1_e, s2_e, g_e, gv_e};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 63;
      m_hold = 0;
      m_live = 0;
    end else begin
      if (m_cnt == 63) m_hold = hold;
      m_cnt  = (m_cnt + 1) % 64;
      m_live = 1;
    end
  end

  int a_be, a_ph, a_wr, a_c8, a_c16, a_s1, a_s2, a_g, a_gv;
  logic prev_be = 0;
  logic [8:0] act, exp_v;

  always @(negedge clk) begin
    act   = {be, phi2, wr, c8, c16, sr1, sr2, gnt, gv};
    exp_v = m_live ? model(m_cnt, m_hold) : 9'd0;
    chk("outputs", act, exp_v);
    chk("inv_be_gv", be & gv, 0);
    chk("inv_phi2_be", phi2 & ~be, 0);
    chk("inv_wr_phi2", wr & ~phi2, 0);
    if (m_live && prev_be && !be) chk("be_fall_at_wrap", m_cnt, 0);
    prev_be = m_live ? be : 1'b0;
    if (m_live) begin
      if (m_cnt == 0) begin
        a_be = 0; a_ph = 0; a_wr = 0; a_c8 = 0; a_c16 = 0;
        a_s1 = 0; a_s2 = 0; a_g = 0; a_gv = 0;
      end
      a_be += be; a_ph += phi2; a_wr += wr; a_c8 += c8; a_c16 += c16;
      a_s1 += sr1; a_s2 += sr2; a_g += gnt; a_gv += gv;
      if (m_cnt == 63) begin
        chk("cyc_c16", a_c16, 16);
        chk("cyc_c8", a_c8, 8);
        chk("cyc_sr1", a_s1, 1);
        chk("cyc_sr2", a_s2, 1);
        if (m_hold == 0) begin
          chk("cyc_be_norm", a_be, 40);
          chk("cyc_phi2_norm", a_ph, 32);
          chk("cyc_wr_norm", a_wr, 1);
          chk("cyc_gnt_norm", a_g, 8);
          chk("cyc_gv_norm", a_gv, 18);
        end else begin
          chk("cyc_be_held", a_be, 0);
          chk("cyc_phi2_held", a_ph, 0);
          chk("cyc_wr_held", a_wr, 0);
          chk("cyc_gnt_held", a_g, 48);
          chk("cyc_gv_held", a_gv, 48);
        end
      end
    end
  end

  task automatic wait_cnt(input int v);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((m_cnt != v || !m_live) && k < 300);
    if (k >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_tick_%0d: timed out, tick=%0d", v, m_cnt);
    end
  endtask

  initial begin
    rst_n = 0;
    hold  = 0;
    #4;
    chk("reset_outputs", {be, phi2, wr, c8, c16, sr1, sr2, gnt, gv}, 9'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("first_gv", gv, 1);
    chk("first_gnt", gnt, 0);
    chk("first_be", be, 0);

    // Hold toggling away from tick 63 must not affect the current or next cycle.
    wait_cnt(10); hold = 1;
    wait_cnt(20); hold = 0;
    wait_cnt(40); hold = 1;
    wait_cnt(62); hold = 0;
    wait_cnt(62);
    chk("wr_at_62", wr, 1);
    wait_cnt(24);
    chk("be_at_24", be, 1);

    // Donate one cycle to SPI.
    wait_cnt(63); hold = 1;
    wait_cnt(0);  hold = 0;
    wait_cnt(24);
    chk("held_gnt_24", gnt, 1);
    chk("held_gv_24", gv, 1);
    chk("held_be_24", be, 0);
    wait_cnt(62);
    chk("held_gv_62", gv, 0);
    chk("held_wr_62", wr, 0);
    wait_cnt(50); hold = 1;
    wait_cnt(60); hold = 0;
    wait_cnt(40);
    chk("after_hold_phi2", phi2, 1);

    // Asynchronous reset mid-cycle.
    wait_cnt(40);
    chk("pre_reset_be", be, 1);
    #3 rst_n = 0;
    #1 chk("async_reset_outputs", {be, phi2, wr, c8, c16, sr1, sr2, gnt, gv}, 9'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("release_gv", gv, 1);
    chk("release_be", be, 0);
    wait_cnt(63);
    wait_cnt(63);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
